// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment display scanner. A prescaler walks through
// NUM_DIGITS slots of SCAN_DIV clocks each. Each slot starts with a blanking
// window of BLANK_CYC clocks. Digit data is latched into shadow registers
// once per frame, so the inputs can change mid-frame without tearing.
module seg7_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int BLANK_CYC  = 2000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7*NUM_DIGITS-1:0]   seg7_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  output logic [6:0]                seg7out,
  output logic                      dp_out,
  output logic [NUM_DIGITS-1:0]     anode,
  output logic                      frame_start
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic             POL       = (ACTIVE_LOW != 0);

  generate
    if (BLANK_CYC < 0 || BLANK_CYC >= SCAN_DIV) begin : g_bad_blank
      $error("seg7_scan_mux: BLANK_CYC must satisfy 0 <= BLANK_CYC < SCAN_DIV");
    end
    if (SCAN_DIV < 4) begin : g_bad_div
      $error("seg7_scan_mux: SCAN_DIV must be at least 4");
    end
    if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("seg7_scan_mux: NUM_DIGITS must be in 2..8");
    end
  endgenerate

  logic [CNT_W-1:0]            cnt;
  logic [IDX_W-1:0]            idx;
  logic                        load_pending;
  logic [NUM_DIGITS-1:0][6:0]  sh_seg;
  logic [NUM_DIGITS-1:0]       sh_dp;
  logic [NUM_DIGITS-1:0]       sh_en;

  logic end_slot;
  logic end_frame;
  logic load;

  assign end_slot  = (cnt == LAST_CNT);
  assign end_frame = end_slot && (idx == LAST_IDX);
  assign load      = end_frame || load_pending;

  // Prescaler and digit index; the frame period does not depend on digit_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      idx          <= '0;
      load_pending <= 1'b1;
    end else begin
      load_pending <= 1'b0;
      if (end_slot) begin
        cnt <= '0;
        idx <= end_frame ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Shadow capture at the frame boundary and on the first clock out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_seg <= '0;
      sh_dp  <= '0;
      sh_en  <= '0;
    end else if (load) begin
      sh_seg <= seg7_in;
      sh_dp  <= dp_in;
      sh_en  <= digit_en;
    end
  end

  logic [6:0]            seg_nxt;
  logic                  dp_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic                  fs_nxt;
  logic                  show;

  // Active-high drive for the current (idx, cnt) state. The cycle that is
  // still loading the shadow is forced blank so stale data never reaches the
  // pins, even when BLANK_CYC is 0.
  always_comb begin
    seg_nxt = '0;
    dp_nxt  = 1'b0;
    an_nxt  = '0;
    show    = !load_pending && (cnt >= BLANK_END) && sh_en[idx];
    fs_nxt  = (cnt == '0) && (idx == '0);
    if (show) begin
      an_nxt[idx] = 1'b1;
      seg_nxt     = sh_seg[idx];
      dp_nxt      = sh_dp[idx];
    end
  end

  // Output register with pin polarity applied.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg7out     <= {7{POL}};
      dp_out      <= POL;
      anode       <= {NUM_DIGITS{POL}};
      frame_start <= 1'b0;
    end else begin
      seg7out     <= seg_nxt ^ {7{POL}};
      dp_out      <= dp_nxt ^ POL;
      anode       <= an_nxt ^ {NUM_DIGITS{POL}};
      frame_start <= fs_nxt;
    end
  end

endmodule
